// File: rtl/mbist_multiplexer_pkg.sv
// Shared MBIST definitions: standard bus widths for the wrapper's data and
// address paths, and the encoding of the normal/test mode select.
package mbist_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;

    typedef enum logic {
        MODE_NORMAL = 1'b0,
        MODE_BIST   = 1'b1
    } mbist_mode_e;

endpackage

// File: rtl/mbist_multiplexer_if.sv
// Bus bundle for the MBIST path multiplexer.
//   master : drives normal_in, bist_in, NbarT; observes the mux outputs
//   slave  : the multiplexer itself
interface mbist_multiplexer_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic [WIDTH-1:0]     normal_in;
    logic [WIDTH-1:0]     bist_in;
    logic                 NbarT;
    logic [WIDTH-1:0]     out;
    logic [WIDTH-1:0]     out_q;
    logic                 mode_q;
    logic                 mode_switch;
    logic [CNT_WIDTH-1:0] switch_cnt;
    logic                 bist_seen;

    modport master (
        output normal_in, bist_in, NbarT,
        input  out, out_q, mode_q, mode_switch, switch_cnt, bist_seen
    );

    modport slave (
        input  normal_in, bist_in, NbarT,
        output out, out_q, mode_q, mode_switch, switch_cnt, bist_seen
    );
endinterface

// File: rtl/mbist_multiplexer_mode_tracker.sv
// Mode tracker: registers the mode select and reports changes to the BIST
// controller.
//   clk, rst     : clock, asynchronous active-high reset
//   mode         : current select (0 normal, 1 BIST)
//   mode_q       : mode registered
//   mode_switch  : one-cycle pulse when the sampled mode differs from mode_q
//   switch_cnt   : saturating count of sampled mode changes
//   bist_seen    : sticky, set once BIST mode has been sampled
module mbist_mode_tracker
    import mbist_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    output logic                 mode_q,
    output logic                 mode_switch,
    output logic [CNT_WIDTH-1:0] switch_cnt,
    output logic                 bist_seen
);
    logic changed;

    assign changed = (mode != mode_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= 1'b0;
            mode_switch <= 1'b0;
            switch_cnt  <= '0;
            bist_seen   <= 1'b0;
        end else begin
            mode_q      <= mode;
            mode_switch <= changed;
            // Hold at all-ones rather than wrapping back to zero.
            if (changed && (switch_cnt != '1))
                switch_cnt <= switch_cnt + 1'b1;
            bist_seen   <= bist_seen | (mode == MODE_BIST);
        end
    end
endmodule

// File: rtl/mbist_multiplexer.sv
// MBIST path multiplexer: steers either the functional bus or the BIST bus
// to the memory under test with zero latency, and provides a registered
// copy of the selected bus plus mode-tracking status.
//   clk, rst : clock, asynchronous active-high reset (registered outputs only)
//   bus      : slave side of mbist_multiplexer_if (inputs normal_in, bist_in,
//              NbarT; outputs out, out_q, mode_q, mode_switch, switch_cnt,
//              bist_seen)
module mbist_multiplexer
    import mbist_pkg::*;
#(
    parameter int WIDTH     = DATA_W,
    parameter int CNT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    mbist_multiplexer_if.slave  bus
);
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_r;

    // A case statement rather than ?: so an unknown select yields an unknown
    // bus instead of a bitwise merge of the two inputs.
    always_comb begin
        out_c = 'x;
        case (bus.NbarT)
            MODE_NORMAL: out_c = bus.normal_in;
            MODE_BIST:   out_c = bus.bist_in;
            default:     out_c = 'x;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_r <= '0;
        else     out_r <= out_c;
    end

    assign bus.out   = out_c;
    assign bus.out_q = out_r;

    mbist_mode_tracker #(.CNT_WIDTH(CNT_WIDTH)) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .mode        (bus.NbarT),
        .mode_q      (bus.mode_q),
        .mode_switch (bus.mode_switch),
        .switch_cnt  (bus.switch_cnt),
        .bist_seen   (bus.bist_seen)
    );
endmodule

// File: tb/tb_mbist_multiplexer.sv
module tb_mbist_multiplexer;
    import mbist_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mbist_multiplexer_if #(.WIDTH(DATA_W), .CNT_WIDTH(8)) ifa ();
    mbist_multiplexer_if #(.WIDTH(ADDR_W), .CNT_WIDTH(8)) ifb ();

    mbist_multiplexer #(.WIDTH(DATA_W), .CNT_WIDTH(8)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    mbist_multiplexer #(.WIDTH(ADDR_W), .CNT_WIDTH(8)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic regs_a(input string t, input logic [7:0] oq, input logic mq,
                          input logic ms, input logic [7:0] cnt, input logic seen);
        chk({t, "_a_out_q"},       32'(ifa.out_q),       32'(oq));
        chk({t, "_a_mode_q"},      32'(ifa.mode_q),      32'(mq));
        chk({t, "_a_mode_switch"}, 32'(ifa.mode_switch), 32'(ms));
        chk({t, "_a_switch_cnt"},  32'(ifa.switch_cnt),  32'(cnt));
        chk({t, "_a_bist_seen"},   32'(ifa.bist_seen),   32'(seen));
    endtask

    task automatic regs_b(input string t, input logic [5:0] oq, input logic mq,
                          input logic ms, input logic [7:0] cnt, input logic seen);
        chk({t, "_b_out_q"},       32'(ifb.out_q),       32'(oq));
        chk({t, "_b_mode_q"},      32'(ifb.mode_q),      32'(mq));
        chk({t, "_b_mode_switch"}, 32'(ifb.mode_switch), 32'(ms));
        chk({t, "_b_switch_cnt"},  32'(ifb.switch_cnt),  32'(cnt));
        chk({t, "_b_bist_seen"},   32'(ifb.bist_seen),   32'(seen));
    endtask

    initial begin
        ifa.normal_in = '0; ifa.bist_in = '0; ifa.NbarT = 1'b0;
        ifb.normal_in = '0; ifb.bist_in = '0; ifb.NbarT = 1'b0;

        // Reset state; out keeps following the inputs while rst is high.
        #2;
        regs_a("rst", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
        regs_b("rst", 6'h00, 1'b0, 1'b0, 8'd0, 1'b0);

        // Tests 1-3 on the 8-bit instance, combinational only.
        ifa.normal_in = 8'hFF; ifa.bist_in = 8'h00; ifa.NbarT = 1'b0;
        #1 chk("t1_a_out", 32'(ifa.out), 32'h00FF);
        ifa.NbarT = 1'b1;
        #1 chk("t2_a_out", 32'(ifa.out), 32'h0000);
        ifa.normal_in = 8'hA5; ifa.bist_in = 8'h5A; ifa.NbarT = 1'b0;
        #1 chk("t3_a_out_n", 32'(ifa.out), 32'h00A5);
        ifa.NbarT = 1'b1;
        #1 chk("t3_a_out_b", 32'(ifa.out), 32'h005A);
        // Clock edges under reset must not have moved the registers.
        @(posedge clk); #1;
        regs_a("rst_hold", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);

        // Test 4, 8-bit.
        ifa.normal_in = 8'h00; ifa.bist_in = 8'hFF; ifa.NbarT = 1'b0;
        #1 chk("t4_a_out_n", 32'(ifa.out), 32'h0000);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        regs_a("t4_idle", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge clk) ifa.NbarT = 1'b1;
        #1 chk("t4_a_out_b", 32'(ifa.out), 32'h00FF);
        @(posedge clk); #1;
        regs_a("t4_sw", 8'hFF, 1'b1, 1'b1, 8'd1, 1'b1);
        @(posedge clk); #1;
        regs_a("t4_hold", 8'hFF, 1'b1, 1'b0, 8'd1, 1'b1);

        // Test 5: toggle every cycle; 1 + 300 changes saturate at 255.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk) ifa.NbarT = ~ifa.NbarT;
            if (i == 99) begin
                @(posedge clk); #1;
                chk("t5_a_cnt_mid", 32'(ifa.switch_cnt), 32'd101);
                chk("t5_a_sw_mid",  32'(ifa.mode_switch), 32'd1);
            end
        end
        @(posedge clk); #1;
        chk("t5_a_cnt_sat", 32'(ifa.switch_cnt), 32'd255);
        chk("t5_a_seen",    32'(ifa.bist_seen),  32'd1);
        chk("t5_a_mode_q",  32'(ifa.mode_q),     32'd1);
        @(posedge clk); #1;
        chk("t5_a_cnt_hold", 32'(ifa.switch_cnt), 32'd255);
        chk("t5_a_sw_low",   32'(ifa.mode_switch), 32'd0);

        // Test 6: asynchronous reset between edges.
        @(posedge clk); #2 rst = 1'b1;
        #1;
        regs_a("t6_async", 8'h00, 1'b0, 1'b0, 8'd0, 1'b0);
        regs_b("t6_async", 6'h00, 1'b0, 1'b0, 8'd0, 1'b0);
        ifa.normal_in = 8'h3C; ifa.NbarT = 1'b0;
        #1 chk("t6_a_out_rst", 32'(ifa.out), 32'h003C);

        // Tests 1-4 repeated on the 6-bit instance.
        ifb.normal_in = 6'h3F; ifb.bist_in = 6'h00; ifb.NbarT = 1'b0;
        #1 chk("t1_b_out", 32'(ifb.out), 32'h003F);
        ifb.NbarT = 1'b1;
        #1 chk("t2_b_out", 32'(ifb.out), 32'h0000);
        ifb.normal_in = 6'h25; ifb.bist_in = 6'h1A; ifb.NbarT = 1'b0;
        #1 chk("t3_b_out_n", 32'(ifb.out), 32'h0025);
        ifb.NbarT = 1'b1;
        #1 chk("t3_b_out_b", 32'(ifb.out), 32'h001A);
        ifb.normal_in = 6'h00; ifb.bist_in = 6'h3F; ifb.NbarT = 1'b0;
        #1 chk("t4_b_out_n", 32'(ifb.out), 32'h0000);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        regs_b("t4b_idle", 6'h00, 1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge clk) ifb.NbarT = 1'b1;
        #1 chk("t4_b_out_b", 32'(ifb.out), 32'h003F);
        @(posedge clk); #1;
        regs_b("t4b_sw", 6'h3F, 1'b1, 1'b1, 8'd1, 1'b1);
        @(posedge clk); #1;
        regs_b("t4b_hold", 6'h3F, 1'b1, 1'b0, 8'd1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
